// File: rtl/piso_stream.sv
// Parallel-in/serial-out shifter with a load handshake, per-word bit order,
// a bit counter with a last-bit flag and gap-free back-to-back reload.
module piso_stream #(
    parameter int WIDE = 4,
    parameter int CW   = $clog2(WIDE)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [WIDE-1:0] din,
    input  logic            lsb_first,
    input  logic            load_valid,
    output logic            load_ready,
    input  logic            sh,
    output logic            sout,
    output logic            sout_valid,
    output logic            last,
    output logic            busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [WIDE-1:0] shreg_q, shreg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            order_q, order_d;

    // Handshake: a word transfers on a rising edge where load_valid && load_ready;
    // the producer must hold din and load_valid steady until that edge.
    // load_ready also opens on the final bit while it is being consumed, so the
    // next word's first bit follows the previous last bit with no idle cycle.
    assign busy       = (state_q == SHIFT);
    assign sout_valid = busy;
    assign last       = busy && (cnt_q == CW'(WIDE - 1));
    assign load_ready = (state_q == IDLE) || (last && sh);
    assign sout       = busy ? (order_q ? shreg_q[0] : shreg_q[WIDE-1]) : 1'b0;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        order_d = order_q;
        if (load_valid && load_ready) begin
            shreg_d = din;
            order_d = lsb_first;
            cnt_d   = '0;
            state_d = SHIFT;
        end else if (busy && sh) begin
            if (last) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                shreg_d = order_q ? (shreg_q >> 1) : (shreg_q << 1);
                cnt_d   = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            order_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            order_q <= order_d;
        end
    end

endmodule

// File: tb/tb_piso_stream.sv
// Bench for piso_stream: 4-bit and 8-bit instances driven in lockstep, checked
// against a bit-queue reference model, a vector table and hand sequences.
module tb_piso_stream;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din8 = '0;
    logic       lsb = 1'b0;
    logic       lv = 1'b0;
    logic       sh = 1'b0;
    logic       ready4, sout4, valid4, last4, busy4;
    logic       ready8, sout8, valid8, last8, busy8;

    int n_chk = 0;
    int n_pass = 0;
    logic armed = 1'b0;

    // Remaining bits of the word in flight, in output order.
    logic exp4_q[$];
    logic exp8_q[$];
    logic rdy4_m, rdy8_m;

    typedef struct {
        logic       r;
        logic [3:0] d;
        logic       l, v, s;
        logic       so, va, la, rd;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    piso_stream #(.WIDE(4)) u4 (
        .clk(clk), .reset(rst_n), .din(din8[3:0]), .lsb_first(lsb),
        .load_valid(lv), .load_ready(ready4), .sh(sh), .sout(sout4),
        .sout_valid(valid4), .last(last4), .busy(busy4)
    );

    piso_stream #(.WIDE(8)) u8 (
        .clk(clk), .reset(rst_n), .din(din8), .lsb_first(lsb),
        .load_valid(lv), .load_ready(ready8), .sh(sh), .sout(sout8),
        .sout_valid(valid8), .last(last8), .busy(busy8)
    );

    // Reference model: a word is a queue of bits; each consumed bit pops one.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp4_q.delete();
            exp8_q.delete();
        end else begin
            rdy4_m = (exp4_q.size() == 0) || (exp4_q.size() == 1 && sh);
            rdy8_m = (exp8_q.size() == 0) || (exp8_q.size() == 1 && sh);
            if (exp4_q.size() != 0 && sh) void'(exp4_q.pop_front());
            if (exp8_q.size() != 0 && sh) void'(exp8_q.pop_front());
            if (lv && rdy4_m)
                for (int i = 0; i < 4; i++) exp4_q.push_back(lsb ? din8[i] : din8[3-i]);
            if (lv && rdy8_m)
                for (int i = 0; i < 8; i++) exp8_q.push_back(lsb ? din8[i] : din8[7-i]);
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic model_check();
        logic e4, e8;
        e4 = (exp4_q.size() != 0) ? exp4_q[0] : 1'b0;
        e8 = (exp8_q.size() != 0) ? exp8_q[0] : 1'b0;
        chk("m4_sout", sout4, e4);
        chk("m4_valid", valid4, exp4_q.size() != 0);
        chk("m4_busy", busy4, exp4_q.size() != 0);
        chk("m4_last", last4, exp4_q.size() == 1);
        chk("m4_ready", ready4, (exp4_q.size() == 0) || (exp4_q.size() == 1 && sh));
        chk("m8_sout", sout8, e8);
        chk("m8_valid", valid8, exp8_q.size() != 0);
        chk("m8_busy", busy8, exp8_q.size() != 0);
        chk("m8_last", last8, exp8_q.size() == 1);
        chk("m8_ready", ready8, (exp8_q.size() == 0) || (exp8_q.size() == 1 && sh));
    endtask

    task automatic drive(input logic r, input logic [7:0] d, input logic l,
                         input logic v, input logic s);
        rst_n = r; din8 = d; lsb = l; lv = v; sh = s;
        #1;
        if (armed) model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk4(input string name, input logic so, input logic va,
                        input logic la, input logic rd);
        chk({name, "_sout"}, sout4, so);
        chk({name, "_valid"}, valid4, va);
        chk({name, "_busy"}, busy4, va);
        chk({name, "_last"}, last4, la);
        chk({name, "_ready"}, ready4, rd);
    endtask

    task automatic chk8(input string name, input logic so, input logic va,
                        input logic la, input logic rd);
        chk({name, "_sout"}, sout8, so);
        chk({name, "_valid"}, valid8, va);
        chk({name, "_busy"}, busy8, va);
        chk({name, "_last"}, last8, la);
        chk({name, "_ready"}, ready8, rd);
    endtask

    task automatic add(input logic [3:0] d, input logic l, input logic v, input logic s,
                       input logic so, input logic va, input logic la, input logic rd);
        vecs.push_back('{1'b1, d, l, v, s, so, va, la, rd});
    endtask

    initial begin
        logic [7:0] bits;

        // MSB first 1101, continuous shift
        add(4'b1101, 0, 1, 1,  0, 0, 0, 1);
        add(4'b0000, 0, 0, 1,  1, 1, 0, 0);
        add(4'b0000, 0, 0, 1,  1, 1, 0, 0);
        add(4'b0000, 0, 0, 1,  0, 1, 0, 0);
        add(4'b0000, 0, 0, 1,  1, 1, 1, 1);
        add(4'b0000, 0, 0, 1,  0, 0, 0, 1);
        // LSB first 1101
        add(4'b1101, 1, 1, 1,  0, 0, 0, 1);
        add(4'b0000, 0, 0, 1,  1, 1, 0, 0);
        add(4'b0000, 0, 0, 1,  0, 1, 0, 0);
        add(4'b0000, 0, 0, 1,  1, 1, 0, 0);
        add(4'b0000, 0, 0, 1,  1, 1, 1, 1);
        add(4'b0000, 0, 0, 1,  0, 0, 0, 1);
        // MSB first 1001 with a 3-cycle stall on the 2nd bit
        add(4'b1001, 0, 1, 1,  0, 0, 0, 1);
        add(4'b0000, 0, 0, 1,  1, 1, 0, 0);
        add(4'b0000, 0, 0, 0,  0, 1, 0, 0);
        add(4'b0000, 0, 0, 0,  0, 1, 0, 0);
        add(4'b0000, 0, 0, 0,  0, 1, 0, 0);
        add(4'b0000, 0, 0, 1,  0, 1, 0, 0);
        add(4'b0000, 0, 0, 1,  0, 1, 0, 0);
        add(4'b0000, 0, 0, 1,  1, 1, 1, 1);
        add(4'b0000, 0, 0, 1,  0, 0, 0, 1);

        @(negedge clk);
        drive(0, 8'h00, 0, 0, 0);
        tick();
        armed = 1'b1;
        drive(0, 8'h00, 0, 0, 0);
        chk4("rst4", 0, 0, 0, 1);
        chk8("rst8", 0, 0, 0, 1);
        tick();

        foreach (vecs[i]) begin
            drive(vecs[i].r, {4'b0, vecs[i].d}, vecs[i].l, vecs[i].v, vecs[i].s);
            chk4($sformatf("vec%0d", i), vecs[i].so, vecs[i].va, vecs[i].la, vecs[i].rd);
            tick();
        end

        // Back-to-back 1101 then 0100 with no gap
        drive(0, 8'h00, 0, 0, 0); tick();
        drive(1, 8'h0D, 0, 1, 1);
        chk4("b2b_load", 0, 0, 0, 1);
        tick();
        bits = 8'b1101_0100;
        for (int i = 0; i < 8; i++) begin
            drive(1, 8'h04, 0, i < 4, 1);
            chk4($sformatf("b2b%0d", i), bits[7-i], 1, i == 3 || i == 7, i == 3 || i == 7);
            tick();
        end
        drive(1, 8'h00, 0, 0, 1);
        chk4("b2b_idle", 0, 0, 0, 1);
        tick();

        // Mid-word load attempt is refused until last&&sh; lsb_first flips mid-word
        drive(1, 8'h0D, 0, 1, 1); tick();
        drive(1, 8'h00, 0, 0, 1); chk4("mid0", 1, 1, 0, 0); tick();
        drive(1, 8'h0A, 1, 1, 1); chk4("mid1", 1, 1, 0, 0); tick();
        drive(1, 8'h0A, 1, 1, 1); chk4("mid2", 0, 1, 0, 0); tick();
        drive(1, 8'h0A, 0, 1, 1); chk4("mid3", 1, 1, 1, 1); tick();
        bits = 8'b1010_0000;
        for (int i = 0; i < 4; i++) begin
            drive(1, 8'h00, 1, 0, 1);
            chk4($sformatf("mid_new%0d", i), bits[7-i], 1, i == 3, i == 3);
            tick();
        end

        // Reset on the 2nd bit discards the word
        drive(1, 8'h0D, 0, 1, 1); tick();
        drive(1, 8'h00, 0, 0, 1); chk4("rmid0", 1, 1, 0, 0); tick();
        drive(0, 8'h00, 0, 0, 1); tick();
        drive(1, 8'h04, 0, 1, 1); chk4("rmid_after", 0, 0, 0, 1); tick();
        bits = 8'b0100_0000;
        for (int i = 0; i < 4; i++) begin
            drive(1, 8'h00, 0, 0, 1);
            chk4($sformatf("rmid_new%0d", i), bits[7-i], 1, i == 3, i == 3);
            tick();
        end

        // WIDE=8 on A5 MSB first
        drive(0, 8'h00, 0, 0, 0); tick();
        drive(1, 8'hA5, 0, 1, 1); chk8("w8_load", 0, 0, 0, 1); tick();
        bits = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            drive(1, 8'h00, 0, 0, 1);
            chk8($sformatf("w8_%0d", i), bits[7-i], 1, i == 7, i == 7);
            tick();
        end
        drive(1, 8'h00, 0, 0, 1); chk8("w8_idle", 0, 0, 0, 1); tick();

        // Randomised traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 40) != 0, 8'($urandom), 1'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/piso_stream.md
Name: piso_stream

Overview:
- Parametrised parallel-in/serial-out shifter; next generation of the team's fixed 4-bit PISO.
- Adds a load handshake, selectable bit order per word, a bit counter and frame-end flag, and back-to-back reload with no idle bit.
- Sits between a parallel word producer and a bit-serial consumer.
- The consumer paces output through the shift enable `sh`.

Parameters:
- WIDE, 4, word width in bits; legal range ≥2.
- CW, $clog2(WIDE), bit-counter width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
- din  input  WIDE  parallel word to serialise.
- lsb_first  input  1  bit order for the word being loaded (1 = LSB first, 0 = MSB first); sampled only at load.
- load_valid  input  1  producer has a word on din.
- load_ready  output  1  block accepts din this cycle.
- sh  input  1  consumer shift enable; advances one bit per cycle when high.
- sout  output  1  current serial bit.
- sout_valid  output  1  sout holds a valid bit of an active word.
- last  output  1  sout is the final bit of the word.
- busy  output  1  a word is in flight.

Behaviour:
- Registered state:
  - FSM state IDLE/SHIFT.
  - shreg[WIDE-1:0], cnt[CW-1:0], order bit.
- Reset (reset==0 at a clk edge) forces:
  - state=IDLE, shreg=0, cnt=0, order=0.
  - Resulting outputs: load_ready=1, sout=0, sout_valid=0, last=0, busy=0.
- Reset mid-word discards the word; no further bits are output.
- Output decode (combinational from registers, plus sh for load_ready):
  - sout:
    - SHIFT and order=0: shreg[WIDE-1].
    - SHIFT and order=1: shreg[0].
    - IDLE: 0.
  - sout_valid = busy = (state==SHIFT).
  - last = (state==SHIFT) && (cnt==WIDE-1).
  - load_ready = (state==IDLE) || (last && sh).
- Load (load_valid && load_ready at a clk edge):
  - shreg<=din, order<=lsb_first, cnt<=0, state<=SHIFT.
  - First bit appears on sout the cycle after load (latency 1).
- SHIFT, sh==1, last==0:
  - order=0: shreg<=shreg<<1.
  - order=1: shreg<=shreg>>1.
  - Zero fill in both cases; cnt<=cnt+1.
- SHIFT, sh==0: full hold. shreg, cnt and outputs are unchanged; stall length is unbounded.
- SHIFT, sh==1, last==1:
  - load_valid==1: reload per the load rule. Next word's first bit follows the previous last bit with no gap.
  - load_valid==0: state<=IDLE, cnt<=0.
- load_valid in SHIFT while not (last && sh): ignored. load_ready=0, din is not captured, and the producer must hold din.
- lsb_first changes while SHIFT: no effect on the word in flight.
- Word throughput: exactly WIDE sh-high cycles per word; cnt never exceeds WIDE-1 and never wraps.
- No X on any output after the first reset edge.

Test Plan:
- Reset, then load din=4'b1101, lsb_first=0, sh=1 continuous:
  - sout=1,1,0,1 on 4 consecutive cycles; last=1 only on the 4th.
  - Then sout_valid=0 and load_ready=1.
- Same word with lsb_first=1:
  - sout=1,0,1,1; busy=1 for exactly 4 cycles.
- Load 4'b1001 MSB-first; drop sh for 3 cycles after the 2nd bit:
  - sout holds 0 and cnt holds 1 during the stall.
  - Sequence resumes 0,1; last asserts only on the 4th bit.
- Back-to-back: 4'b1101 then 4'b0100, load_valid held high, sh=1:
  - load_ready=1 on the last bit of the first word.
  - sout=1,1,0,1,0,1,0,0 with no gap; sout_valid stays 1 for 8 cycles.
- Load during mid-word (cnt=1) with a different din=4'b1010:
  - load_ready=0; the original word completes unchanged.
  - The new word is accepted only on the last&&sh cycle.
- Assert reset low on the 2nd bit of 4'b1101:
  - Next cycle sout=0, sout_valid=0, busy=0, load_ready=1.
  - The next load serialises a fresh 4'b0100 correctly; also rerun with WIDE=8 on 8'hA5 MSB-first → 1,0,1,0,0,1,0,1.
